// File: rtl/alarm_ctrl_pkg.sv
// Shared watch encodings and alarm defaults.
// Edit state encodings double as the edit_field display-select values.
package watch_pkg;

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_MIN  = 2'd1,
    E_HOUR = 2'd2
  } edit_state_t;

  typedef enum logic [1:0] {
    A_IDLE   = 2'd0,
    A_RING   = 2'd1,
    A_SNOOZE = 2'd2
  } alarm_state_t;

  localparam int DEF_RING_SECONDS   = 60;
  localparam int DEF_SNOOZE_SECONDS = 300;
  localparam int DEF_MAX_SNOOZE     = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Key, time and alarm-output bundle between the watch core and alarm_ctrl.
interface alarm_ctrl_if;
  logic       sec_tick;
  logic       mode_key;
  logic       adj_key;
  logic       stop_key;
  logic       alarm_on;
  logic [7:0] cur_hour;
  logic [7:0] cur_minute;
  logic [7:0] cur_second;
  logic [7:0] alm_hour;
  logic [7:0] alm_minute;
  logic       minute_set;
  logic       hour_set;
  logic [1:0] edit_field;
  logic       ringing;
  logic       buzzer;

  modport master (
    output sec_tick, mode_key, adj_key, stop_key, alarm_on,
    output cur_hour, cur_minute, cur_second, alm_hour, alm_minute,
    input  minute_set, hour_set, edit_field, ringing, buzzer
  );

  modport slave (
    input  sec_tick, mode_key, adj_key, stop_key, alarm_on,
    input  cur_hour, cur_minute, cur_second, alm_hour, alm_minute,
    output minute_set, hour_set, edit_field, ringing, buzzer
  );
endinterface

// File: rtl/alarm_ctrl_match.sv
// Current-time vs alarm-time compare with rising-edge detect.
// match_q resets high so a reset landing on a matching time does not ring.
module alarm_match (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] i_cur_hour,
  input  logic [7:0] i_cur_minute,
  input  logic [7:0] i_cur_second,
  input  logic [7:0] i_alm_hour,
  input  logic [7:0] i_alm_minute,
  output logic       o_trigger
);

  logic w_match;
  logic r_match_q;

  assign w_match = (i_cur_hour == i_alm_hour) && (i_cur_minute == i_alm_minute) &&
                   (i_cur_second == 8'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_match_q <= 1'b1;
    else       r_match_q <= w_match;
  end

  assign o_trigger = w_match & ~r_match_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm edit sequencer plus ring/snooze controller driving the buzzer.
// Both FSMs, the second counter and the snooze counter live here.
module alarm_ctrl
  import watch_pkg::*;
#(
  parameter int RING_SECONDS   = DEF_RING_SECONDS,
  parameter int SNOOZE_SECONDS = DEF_SNOOZE_SECONDS,
  parameter int MAX_SNOOZE     = DEF_MAX_SNOOZE
) (
  input logic         clock,
  input logic         reset,
  alarm_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(max_int(RING_SECONDS, SNOOZE_SECONDS) + 1);
  localparam int SNZ_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam logic [CNT_W-1:0] RING_LIM = CNT_W'(RING_SECONDS);
  localparam logic [CNT_W-1:0] SNZ_LIM  = CNT_W'(SNOOZE_SECONDS);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [SNZ_W-1:0] SNZ_MAX  = SNZ_W'(MAX_SNOOZE);

  edit_state_t  r_e_state, w_e_next;
  alarm_state_t r_a_state, w_a_next;
  logic [CNT_W-1:0] r_cnt;
  logic [SNZ_W-1:0] r_snz;
  logic r_minute_set, r_hour_set, r_ringing, r_buzzer;
  logic w_trigger, w_cnt_clr, w_snz_clr, w_snz_inc;
  logic w_min_pulse, w_hour_pulse, w_buzz_next, w_edit_en;

  alarm_match u_match (
    .clock        (clock),
    .reset        (reset),
    .i_cur_hour   (bus.cur_hour),
    .i_cur_minute (bus.cur_minute),
    .i_cur_second (bus.cur_second),
    .i_alm_hour   (bus.alm_hour),
    .i_alm_minute (bus.alm_minute),
    .o_trigger    (w_trigger)
  );

  // Alarm FSM: alarm_on low > stop > adj > timeout
  always_comb begin
    w_a_next  = r_a_state;
    w_cnt_clr = 1'b0;
    w_snz_clr = 1'b0;
    w_snz_inc = 1'b0;
    case (r_a_state)
      A_IDLE: begin
        if (w_trigger && bus.alarm_on && (r_e_state == E_IDLE)) begin
          w_a_next  = A_RING;
          w_cnt_clr = 1'b1;
          w_snz_clr = 1'b1;
        end
      end
      A_RING: begin
        if (!bus.alarm_on || bus.stop_key) begin
          w_a_next = A_IDLE;
        end else if (bus.adj_key) begin
          if (r_snz < SNZ_MAX) begin
            w_a_next  = A_SNOOZE;
            w_snz_inc = 1'b1;
            w_cnt_clr = 1'b1;
          end else begin
            w_a_next = A_IDLE;
          end
        end else if (r_cnt == RING_LIM) begin
          w_a_next = A_IDLE;
        end
      end
      A_SNOOZE: begin
        if (!bus.alarm_on || bus.stop_key) begin
          w_a_next = A_IDLE;
        end else if (r_cnt == SNZ_LIM) begin
          w_a_next  = A_RING;
          w_cnt_clr = 1'b1;
        end
      end
      default: w_a_next = A_IDLE;
    endcase
  end

  // Buzzer restarts high on every entry to ring, then follows sec_tick
  always_comb begin
    w_buzz_next = 1'b0;
    if (w_a_next == A_RING) begin
      if (r_a_state != A_RING) w_buzz_next = 1'b1;
      else if (bus.sec_tick)   w_buzz_next = ~r_buzzer;
      else                     w_buzz_next = r_buzzer;
    end
  end

  // Keys go to the edit FSM only while the alarm stays idle
  assign w_edit_en = (r_a_state == A_IDLE) && (w_a_next == A_IDLE);

  always_comb begin
    w_e_next     = r_e_state;
    w_min_pulse  = 1'b0;
    w_hour_pulse = 1'b0;
    if (w_edit_en) begin
      case (r_e_state)
        E_IDLE: if (bus.mode_key) w_e_next = E_MIN;
        E_MIN: begin
          if (bus.mode_key)     w_e_next    = E_HOUR;
          else if (bus.adj_key) w_min_pulse = 1'b1;
        end
        E_HOUR: begin
          if (bus.mode_key)     w_e_next     = E_IDLE;
          else if (bus.adj_key) w_hour_pulse = 1'b1;
        end
        default: w_e_next = E_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_e_state    <= E_IDLE;
      r_a_state    <= A_IDLE;
      r_cnt        <= '0;
      r_snz        <= '0;
      r_minute_set <= 1'b0;
      r_hour_set   <= 1'b0;
      r_ringing    <= 1'b0;
      r_buzzer     <= 1'b0;
    end else begin
      r_e_state    <= w_e_next;
      r_a_state    <= w_a_next;
      r_minute_set <= w_min_pulse;
      r_hour_set   <= w_hour_pulse;
      r_ringing    <= (w_a_next == A_RING);
      r_buzzer     <= w_buzz_next;
      if (w_cnt_clr)
        r_cnt <= '0;
      else if (bus.sec_tick && (r_a_state != A_IDLE) && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + 1'b1;
      if (w_snz_clr)      r_snz <= '0;
      else if (w_snz_inc) r_snz <= r_snz + 1'b1;
    end
  end

  assign bus.minute_set = r_minute_set;
  assign bus.hour_set   = r_hour_set;
  assign bus.edit_field = r_e_state;
  assign bus.ringing    = r_ringing;
  assign bus.buzzer     = r_buzzer;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: stimulus queues expected output events,
// a negedge monitor pops and compares each pulse or level change it observes.
module tb_alarm_ctrl;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  alarm_ctrl_if bus ();

  alarm_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  localparam int K_MODE = 0, K_ADJ = 1, K_STOP = 2, K_SEC = 3, K_STOPADJ = 4;

  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  // {minute_set, hour_set, edit_field, ringing, buzzer}
  function automatic logic [5:0] S(input bit ms, input bit hs, input logic [1:0] ef,
                                   input bit r, input bit b);
    return {ms, hs, ef, r, b};
  endfunction

  function automatic logic [5:0] snap();
    return {bus.minute_set, bus.hour_set, bus.edit_field, bus.ringing, bus.buzzer};
  endfunction

  // Monitor
  initial begin
    logic [3:0] prev_lvl;
    logic [5:0] obs, e;
    prev_lvl = 4'b0;
    forever begin
      @(negedge clock);
      obs = snap();
      if (obs[5] || obs[4] || (obs[3:0] !== prev_lvl)) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event t=%0t got=%b required=none", $time, obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_err++;
            $display("FAIL event t=%0t got=%b required=%b", $time, obs, e);
          end
        end
      end
      prev_lvl = obs[3:0];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input int key);
    case (key)
      K_MODE:    bus.mode_key = 1'b1;
      K_ADJ:     bus.adj_key  = 1'b1;
      K_STOP:    bus.stop_key = 1'b1;
      K_SEC:     bus.sec_tick = 1'b1;
      K_STOPADJ: begin bus.stop_key = 1'b1; bus.adj_key = 1'b1; end
      default: ;
    endcase
    step();
    bus.mode_key = 1'b0;
    bus.adj_key  = 1'b0;
    bus.stop_key = 1'b0;
    bus.sec_tick = 1'b0;
  endtask

  task automatic drain(input int lat, input string name);
    for (int i = 0; i < lat && exp_q.size() != 0; i++) begin
      @(negedge clock);
      #1;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_key(input int key, input int n_exp, input logic [5:0] e0,
                        input logic [5:0] e1, input int lat, input string name);
    step();
    step();
    if (n_exp > 0) exp_q.push_back(e0);
    if (n_exp > 1) exp_q.push_back(e1);
    press(key);
    if (n_exp > 0) drain(lat, name);
  endtask

  task automatic ticks_quiet(input int n);
    for (int i = 0; i < n; i++) do_key(K_SEC, 0, 6'b0, 6'b0, 1, "tick");
  endtask

  task automatic ring_start(input bit leave, input string name);
    step();
    bus.cur_hour = 8'd7; bus.cur_minute = 8'd29; bus.cur_second = 8'd59;
    step();
    step();
    exp_q.push_back(S(0, 0, 2'd0, 1, 1));
    bus.cur_minute = 8'd30; bus.cur_second = 8'd0;
    step();
    drain(1, name);
    if (leave) begin
      step();
      bus.cur_second = 8'd1;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.sec_tick = 1'b0; bus.mode_key = 1'b0; bus.adj_key = 1'b0; bus.stop_key = 1'b0;
    bus.alarm_on = 1'b0;
    bus.cur_hour = 8'd12; bus.cur_minute = 8'd0; bus.cur_second = 8'd5;
    bus.alm_hour = 8'd7;  bus.alm_minute = 8'd30;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (snap() !== 6'b0) begin
      n_err++;
      $display("FAIL reset_state: got=%b required=000000", snap());
    end
    step();
    reset = 1'b0;

    // Edit sequencing
    do_key(K_MODE, 1, S(0, 0, 2'd1, 0, 0), 6'b0, 1, "mode_to_min");
    for (int i = 0; i < 3; i++)
      do_key(K_ADJ, 1, S(1, 0, 2'd1, 0, 0), 6'b0, 1, $sformatf("minute_set_%0d", i));
    do_key(K_MODE, 1, S(0, 0, 2'd2, 0, 0), 6'b0, 1, "mode_to_hour");
    do_key(K_ADJ,  1, S(0, 1, 2'd2, 0, 0), 6'b0, 1, "hour_set");
    do_key(K_MODE, 1, S(0, 0, 2'd0, 0, 0), 6'b0, 1, "mode_to_idle");

    // Ring with buzzer toggling, auto-stop after 60 ticks
    bus.alarm_on = 1'b1;
    ring_start(1'b0, "ring_first");
    for (int k = 1; k <= 60; k++) begin
      if (k == 6) bus.cur_second = 8'd1;
      if (k == 60)
        do_key(K_SEC, 2, S(0, 0, 2'd0, 1, 1), S(0, 0, 2'd0, 0, 0), 2, "ring_timeout");
      else
        do_key(K_SEC, 1, S(0, 0, 2'd0, 1, (k % 2) == 0), 6'b0, 1,
               $sformatf("buzz_tick_%0d", k));
    end

    // Three snoozes, fourth adj stops
    ring_start(1'b1, "ring_snz");
    for (int s = 1; s <= 3; s++) begin
      do_key(K_ADJ, 1, S(0, 0, 2'd0, 0, 0), 6'b0, 1, $sformatf("snooze_%0d", s));
      ticks_quiet(299);
      do_key(K_SEC, 1, S(0, 0, 2'd0, 1, 1), 6'b0, 2, $sformatf("rering_%0d", s));
    end
    do_key(K_ADJ, 1, S(0, 0, 2'd0, 0, 0), 6'b0, 1, "snooze_limit_stop");
    ticks_quiet(310);

    // Stop+adj together inside the matching second, no retrigger
    ring_start(1'b0, "ring_stopadj");
    do_key(K_STOPADJ, 1, S(0, 0, 2'd0, 0, 0), 6'b0, 1, "stop_over_adj");
    repeat (5) step();
    bus.cur_second = 8'd1;
    ticks_quiet(3);

    // alarm_on dropped mid-ring, then mid-snooze
    ring_start(1'b1, "ring_aoff");
    step();
    exp_q.push_back(S(0, 0, 2'd0, 0, 0));
    bus.alarm_on = 1'b0;
    step();
    drain(1, "alarm_off_ring");
    bus.alarm_on = 1'b1;
    ring_start(1'b1, "ring_aoff_snz");
    do_key(K_ADJ, 1, S(0, 0, 2'd0, 0, 0), 6'b0, 1, "snooze_before_off");
    ticks_quiet(5);
    bus.alarm_on = 1'b0;
    step();
    ticks_quiet(310);
    bus.alarm_on = 1'b1;

    // Reset onto 00:00:00 with alarm 00:00
    step();
    reset = 1'b1;
    bus.cur_hour = 8'd0; bus.cur_minute = 8'd0; bus.cur_second = 8'd0;
    bus.alm_hour = 8'd0; bus.alm_minute = 8'd0;
    repeat (2) step();
    reset = 1'b0;
    repeat (6) step();

    // Match while editing does not ring
    bus.alm_hour = 8'd7; bus.alm_minute = 8'd30;
    do_key(K_MODE, 1, S(0, 0, 2'd1, 0, 0), 6'b0, 1, "edit_min_for_match");
    bus.cur_hour = 8'd7; bus.cur_minute = 8'd29; bus.cur_second = 8'd59;
    repeat (2) step();
    bus.cur_minute = 8'd30; bus.cur_second = 8'd0;
    repeat (4) step();
    do_key(K_MODE, 1, S(0, 0, 2'd2, 0, 0), 6'b0, 1, "edit_hour_in_match");
    do_key(K_MODE, 1, S(0, 0, 2'd0, 0, 0), 6'b0, 1, "edit_idle_in_match");
    repeat (3) step();
    bus.cur_second = 8'd1;

    // mode_key ignored while ringing; asynchronous reset mid-ring
    ring_start(1'b1, "ring_async");
    do_key(K_MODE, 0, 6'b0, 6'b0, 1, "mode_in_ring");
    repeat (3) step();
    #1;
    exp_q.push_back(S(0, 0, 2'd0, 0, 0));
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.ringing !== 1'b0 || bus.buzzer !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: ringing=%b buzzer=%b required 0 0", bus.ringing, bus.buzzer);
    end
    drain(1, "async_reset_event");
    repeat (2) step();
    reset = 1'b0;
    repeat (6) step();
    drain(1, "final_queue");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
